// File: rtl/s_div_pkg.sv
// Shared constants and state encodings for the sequential signed divider.
// Contents:
//   N          divisor/remainder width (dividend/quotient width is 2N)
//   CntW       width of the iteration counter, $clog2(2N)
//   state_t    FSM state type with its encodings (idle, calc, fix, done)
//   special-case encodings for divide-by-zero and overflow
package s_div_pkg;

  localparam int unsigned N    = 4;
  localparam int unsigned CntW = $clog2(2 * N);

  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StCalc = 2'd1;
  localparam state_t StFix  = 2'd2;
  localparam state_t StDone = 2'd3;

  // First and last values of the down-counting iteration counter
  localparam logic [CntW-1:0] CntFirst = CntW'(2 * N - 1);
  localparam logic [CntW-1:0] CntZero  = '0;

  // Divide-by-zero reports an all-ones quotient
  localparam logic [2*N-1:0] DbzQuotient = '1;

  // Overflow operands: most negative dividend divided by -1
  localparam logic [2*N-1:0] OvfDividend = {1'b1, {(2 * N - 1){1'b0}}};
  localparam logic [N-1:0]   OvfDivisor  = '1;

endpackage

// File: rtl/s_seq_div8_4_csub.sv
// Unsigned conditional subtractor used for the restoring-division trial step.
// Ports:
//   a       minuend (shifted partial remainder)
//   b       subtrahend (divisor magnitude)
//   diff    a - b, truncated to Width bits
//   nonneg  high when a >= b, i.e. the difference is valid to keep
module s_seq_div8_4_csub #(
  parameter int unsigned Width = 5
) (
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] diff,
  output logic             nonneg
);

  logic [Width:0] full;

  // Extra top bit acts as the borrow out
  assign full   = {1'b0, a} - {1'b0, b};
  assign diff   = full[Width-1:0];
  assign nonneg = ~full[Width];

endmodule

// File: rtl/s_seq_div8_4.sv
// Sequential signed restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, valid/ready on both sides.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   in_valid/in_ready     operand handshake (ready only while idle)
//   dividend, divisor     signed operands, sampled on the accepting edge
//   out_valid/out_ready   result handshake; outputs held while waiting
//   quotient              signed quotient, truncated toward zero
//   remainder             signed remainder, sign follows the dividend
//   div_by_zero, overflow special-case flags (mutually exclusive)
module s_seq_div8_4
  import s_div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [2*N-1:0] OneQ = {{(2 * N - 1){1'b0}}, 1'b1};
  localparam logic [N:0]     OneD = {{N{1'b0}}, 1'b1};
  localparam logic [N-1:0]   OneR = {{(N - 1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  // Set for the one cycle between accepting operands and dispatching them
  logic              load_q, load_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  // Dividend magnitude; quotient bits shift in at the LSB as it drains
  logic [2*N-1:0]    mag_q, mag_d;
  logic [N:0]        dvs_q, dvs_d;
  logic [N:0]        rem_q, rem_d;
  logic              dvd_neg_q, dvd_neg_d;
  logic              q_neg_q, q_neg_d;
  logic              dbz_pend_q, dbz_pend_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [2*N-1:0]    quo_out_q, quo_out_d;
  logic [N-1:0]      rem_out_q, rem_out_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic [2*N-1:0]    dvd_abs;
  logic [N:0]        dvs_sx;
  logic [N:0]        dvs_abs;
  logic [N:0]        shift_in;
  logic [N:0]        trial_diff;
  logic              trial_ok;
  logic              unused_rem_msb;

  assign in_ready  = !rst && (state_q == StIdle) && !load_q;
  assign out_valid = (state_q == StDone);
  assign accept    = in_valid && in_ready;

  assign quotient    = quo_out_q;
  assign remainder   = rem_out_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

  // Magnitudes; the most negative dividend maps to 2^(2N-1) unsigned
  assign dvd_abs = dividend[2*N-1] ? (~dividend + OneQ) : dividend;
  assign dvs_sx  = {divisor[N-1], divisor};
  assign dvs_abs = divisor[N-1] ? (~dvs_sx + OneD) : dvs_sx;

  // Partial remainder is always below |divisor| <= 2^(N-1), so its MSB is zero
  assign shift_in       = {rem_q[N-1:0], mag_q[2*N-1]};
  assign unused_rem_msb = rem_q[N];

  s_seq_div8_4_csub #(
    .Width (N + 1)
  ) u_csub (
    .a      (shift_in),
    .b      (dvs_q),
    .diff   (trial_diff),
    .nonneg (trial_ok)
  );

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    dvd_neg_d  = dvd_neg_q;
    q_neg_d    = q_neg_q;
    dbz_pend_d = dbz_pend_q;
    ovf_pend_d = ovf_pend_q;
    quo_out_d  = quo_out_q;
    rem_out_d  = rem_out_q;
    dbz_d      = dbz_q;
    ovf_d      = ovf_q;

    case (state_q)
      StIdle: begin
        if (load_q) begin
          load_d = 1'b0;
          if (dbz_pend_q) begin
            quo_out_d = DbzQuotient;
            rem_out_d = '0;
            dbz_d     = 1'b1;
            ovf_d     = 1'b0;
            state_d   = StDone;
          end else if (ovf_pend_q) begin
            quo_out_d = OvfDividend;
            rem_out_d = '0;
            dbz_d     = 1'b0;
            ovf_d     = 1'b1;
            state_d   = StDone;
          end else begin
            rem_d   = '0;
            cnt_d   = CntFirst;
            state_d = StCalc;
          end
        end else if (accept) begin
          load_d     = 1'b1;
          mag_d      = dvd_abs;
          dvs_d      = dvs_abs;
          dvd_neg_d  = dividend[2*N-1];
          q_neg_d    = dividend[2*N-1] ^ divisor[N-1];
          dbz_pend_d = (divisor == '0);
          ovf_pend_d = (dividend == OvfDividend) && (divisor == OvfDivisor);
        end
      end

      StCalc: begin
        rem_d = trial_ok ? trial_diff : shift_in;
        mag_d = {mag_q[2*N-2:0], trial_ok};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntZero) begin
          state_d = StFix;
        end
      end

      StFix: begin
        quo_out_d = q_neg_q ? (~mag_q + OneQ) : mag_q;
        rem_out_d = dvd_neg_q ? (~rem_q[N-1:0] + OneR) : rem_q[N-1:0];
        dbz_d     = 1'b0;
        ovf_d     = 1'b0;
        state_d   = StDone;
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      load_q     <= 1'b0;
      cnt_q      <= '0;
      mag_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      dvd_neg_q  <= 1'b0;
      q_neg_q    <= 1'b0;
      dbz_pend_q <= 1'b0;
      ovf_pend_q <= 1'b0;
      quo_out_q  <= '0;
      rem_out_q  <= '0;
      dbz_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_q     <= load_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      dvs_q      <= dvs_d;
      rem_q      <= rem_d;
      dvd_neg_q  <= dvd_neg_d;
      q_neg_q    <= q_neg_d;
      dbz_pend_q <= dbz_pend_d;
      ovf_pend_q <= ovf_pend_d;
      quo_out_q  <= quo_out_d;
      rem_out_q  <= rem_out_d;
      dbz_q      <= dbz_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule
